// File: rtl/adder_tb_pkg.sv
// Shared definitions for the adder regression sequencer: FSM states,
// result widths and the LFSR polynomial used for random vectors.
package adder_tb_pkg;

  localparam int ERR_W = 16;
  localparam int IDX_W = 32;

  localparam logic [ERR_W-1:0] ERR_SAT = 16'hFFFF;

  // Galois feedback mask for x^32 + x^22 + x^2 + x + 1 (right-shifting form)
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // One Galois LFSR step: shift right, fold the dropped bit into the taps
  function automatic logic [31:0] lfsr_step(input logic [31:0] cur);
    return {1'b0, cur[31:1]} ^ (cur[0] ? LFSR_TAPS : 32'h0);
  endfunction

endpackage

// File: rtl/lfsr32.sv
// 32-bit Galois LFSR with synchronous load; q is the current state.
module lfsr32
  import adder_tb_pkg::*;
#(
  parameter logic [31:0] RESET_VAL = 32'hACE1_2011
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        en,
  output logic [31:0] q
);

  // State register: load has priority over advancing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RESET_VAL;
    end else if (load) begin
      q <= seed;
    end else if (en) begin
      q <= lfsr_step(q);
    end
  end

endmodule

// File: rtl/adder_check_seq.sv
// Stimulus sequencer and result checker for the adder regression: drives
// exhaustive or LFSR vectors, realigns results through LAT stages, counts
// mismatching vectors and reports the first failing index.
module adder_check_seq
  import adder_tb_pkg::*;
#(
  parameter int          N    = 8,
  parameter int          MODE = 0,
  parameter int          NVEC = 1024,
  parameter int          LAT  = 0,
  parameter logic [31:0] SEED = 32'hACE1_2011
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic [N-1:0]     a,
  output logic [N-1:0]     b,
  output logic             cin,
  input  logic [N-1:0]     s_ref,
  input  logic [N-1:0]     s_duv,
  input  logic             cout_ref,
  input  logic             cout_duv,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [IDX_W-1:0] first_err_idx
);

  // Vector width {cin,b,a}; the internal index is one bit wider than the
  // reported index so a full 2^33 sweep at N=16 still terminates.
  localparam int VW = 2 * N + 1;
  localparam int CW = IDX_W + 1;
  localparam logic [CW-1:0] LAST_IDX = (MODE == 0) ? ((CW'(1) << VW) - CW'(1))
                                                   : (CW'(NVEC) - CW'(1));

  state_t           state_q;
  state_t           next_state;
  logic [CW-1:0]    idx_q;
  logic [VW-1:0]    vec_q;
  logic [VW-1:0]    first_vec;
  logic [VW-1:0]    next_vec;
  logic [31:0]      lfsr_q;
  logic             lfsr_en;
  logic             start_run;
  logic             run_step;
  logic             is_last;
  logic             cmp_valid;
  logic             cmp_last;
  logic [IDX_W-1:0] cmp_idx;
  logic             mismatch;
  logic [ERR_W-1:0] err_next;
  logic [IDX_W-1:0] first_next;
  logic             busy_d;
  logic             done_d;
  logic             pass_d;

  assign start_run = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && start && !abort;
  assign is_last   = (idx_q == LAST_IDX);
  assign run_step  = (state_q == ST_RUN) && !abort && !is_last;
  assign lfsr_en   = run_step && (MODE != 0);

  // The LFSR state always equals the random vector currently on the outputs
  lfsr32 #(
    .RESET_VAL (SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (start_run),
    .seed  (SEED),
    .en    (lfsr_en),
    .q     (lfsr_q)
  );

  // Select vector 0 and the following vector for the active generation mode
  always_comb begin
    first_vec = '0;
    next_vec  = VW'(idx_q + CW'(1));
    if (MODE != 0) begin
      first_vec = VW'({1'b0, SEED});
      next_vec  = VW'({1'b0, lfsr_step(lfsr_q)});
    end
  end

  // Valid/index alignment: with no latency the live vector is compared directly
  generate
    if (LAT == 0) begin : g_nolat
      assign cmp_valid = (state_q == ST_RUN);
      assign cmp_last  = is_last;
      assign cmp_idx   = idx_q[IDX_W-1:0];
    end else begin : g_lat
      logic [LAT-1:0]            pipe_valid;
      logic [LAT-1:0]            pipe_last;
      logic [LAT-1:0][IDX_W-1:0] pipe_idx;

      // Shift each emitted vector's tag LAT stages; abort empties the pipe
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pipe_valid <= '0;
          pipe_last  <= '0;
          pipe_idx   <= '0;
        end else if (abort) begin
          pipe_valid <= '0;
          pipe_last  <= '0;
        end else begin
          pipe_valid[0] <= (state_q == ST_RUN);
          pipe_last[0]  <= is_last;
          pipe_idx[0]   <= idx_q[IDX_W-1:0];
          for (int i = 1; i < LAT; i++) begin
            pipe_valid[i] <= pipe_valid[i-1];
            pipe_last[i]  <= pipe_last[i-1];
            pipe_idx[i]   <= pipe_idx[i-1];
          end
        end
      end

      assign cmp_valid = pipe_valid[LAT-1];
      assign cmp_last  = pipe_last[LAT-1];
      assign cmp_idx   = pipe_idx[LAT-1];
    end
  endgenerate

  assign mismatch = cmp_valid && !abort &&
                    ((s_ref != s_duv) || (cout_ref != cout_duv));

  // Error accounting: one count per failing vector, first index latched once
  always_comb begin
    err_next   = err_cnt;
    first_next = first_err_idx;
    if (start_run) begin
      err_next   = '0;
      first_next = '1;
    end else if (mismatch) begin
      if (err_cnt != ERR_SAT) begin
        err_next = err_cnt + ERR_W'(1);
      end
      if (err_cnt == '0) begin
        first_next = cmp_idx;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= next_state;
    end
  end

  // FSM next-state logic; abort overrides everything else
  always_comb begin
    next_state = state_q;
    if (abort) begin
      next_state = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) next_state = ST_RUN;
        end
        ST_RUN: begin
          if (is_last) next_state = (LAT == 0) ? ST_DONE : ST_DRAIN;
        end
        ST_DRAIN: begin
          if (cmp_valid && cmp_last) next_state = ST_DONE;
        end
        default: next_state = ST_IDLE;
      endcase
    end
  end

  // FSM outputs decoded from the next state so the status flags are registered
  always_comb begin
    busy_d = (next_state == ST_RUN) || (next_state == ST_DRAIN);
    done_d = (next_state == ST_DONE);
    pass_d = (next_state == ST_DONE) && (err_next == '0);
  end

  // Status flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
    end else begin
      busy <= busy_d;
      done <= done_d;
      pass <= pass_d;
    end
  end

  // Vector index, operand register and result counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q         <= '0;
      vec_q         <= '0;
      err_cnt       <= '0;
      first_err_idx <= '1;
    end else begin
      if (start_run) begin
        idx_q <= '0;
        vec_q <= first_vec;
      end else if (run_step) begin
        idx_q <= idx_q + CW'(1);
        vec_q <= next_vec;
      end
      err_cnt       <= err_next;
      first_err_idx <= first_next;
    end
  end

  assign a   = vec_q[N-1:0];
  assign b   = vec_q[2*N-1:N];
  assign cin = vec_q[2*N];

endmodule

// File: tb/tb_adder_check_seq.sv
// Testbench for adder_check_seq: three instances (N=4 exhaustive LAT=0,
// N=4 exhaustive LAT=2, N=8 random NVEC=100 LAT=3) with bench-side adders.
module tb_adder_check_seq;

  localparam logic [31:0] SEED_V = 32'hACE1_2011;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic abort;
  int   fault;
  int   checks = 0;
  int   errors = 0;

  logic [3:0]  a0, b0, s_ref0, s_duv0;
  logic        cin0, cout_ref0, cout_duv0, busy0, done0, pass0;
  logic [15:0] err0;
  logic [31:0] first0;

  logic [3:0]  a2, b2, s_ref2, s_duv2;
  logic        cin2, cout_ref2, cout_duv2, busy2, done2, pass2;
  logic [15:0] err2;
  logic [31:0] first2;

  logic [7:0]  a_r, b_r, s_ref_r;
  logic        cin_r, cout_ref_r, busy_r, done_r, pass_r;
  logic [15:0] err_r;
  logic [31:0] first_r;

  logic [4:0] sum0, duv0, sum2_raw, sum2_p1, sum2_p2, duv2;
  logic [8:0] sumr_raw, sumr_p1, sumr_p2, sumr_p3;

  typedef struct {
    int          fault;
    bit          busy_start;
    int          exp_err;
    logic [31:0] exp_first;
    bit          exp_pass;
  } run_t;

  run_t runs[4];

  always #5 clk = ~clk;

  // Faulty DUV behaviours: 1 sum bit0 stuck-0, 2 cout stuck-1, 3 sum inverted and cout stuck-1
  function automatic logic [4:0] fault5(input int f, input logic [4:0] s);
    case (f)
      1:       return {s[4:1], 1'b0};
      2:       return {1'b1, s[3:0]};
      3:       return {1'b1, ~s[3:0]};
      default: return s;
    endcase
  endfunction

  // Independent per-tap description of the 32-bit Galois LFSR
  function automatic logic [31:0] model_step(input logic [31:0] s);
    logic [31:0] n;
    logic        fb;
    fb = s[0];
    for (int i = 0; i < 31; i++) n[i] = s[i+1];
    n[31] = fb;
    n[21] = n[21] ^ fb;
    n[1]  = n[1] ^ fb;
    n[0]  = n[0] ^ fb;
    return n;
  endfunction

  // Reference adders and latency pipelines
  always_comb begin
    sum0     = {1'b0, a0} + {1'b0, b0} + {4'b0, cin0};
    sum2_raw = {1'b0, a2} + {1'b0, b2} + {4'b0, cin2};
    sumr_raw = {1'b0, a_r} + {1'b0, b_r} + {8'b0, cin_r};
  end

  always @(posedge clk) begin
    sum2_p1 <= sum2_raw;
    sum2_p2 <= sum2_p1;
    sumr_p1 <= sumr_raw;
    sumr_p2 <= sumr_p1;
    sumr_p3 <= sumr_p2;
  end

  assign duv0       = fault5(fault, sum0);
  assign duv2       = fault5(fault, sum2_p2);
  assign s_ref0     = sum0[3:0];
  assign cout_ref0  = sum0[4];
  assign s_duv0     = duv0[3:0];
  assign cout_duv0  = duv0[4];
  assign s_ref2     = sum2_p2[3:0];
  assign cout_ref2  = sum2_p2[4];
  assign s_duv2     = duv2[3:0];
  assign cout_duv2  = duv2[4];
  assign s_ref_r    = sumr_p3[7:0];
  assign cout_ref_r = sumr_p3[8];

  adder_check_seq #(.N(4), .MODE(0), .NVEC(1024), .LAT(0), .SEED(SEED_V)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .a(a0), .b(b0), .cin(cin0),
    .s_ref(s_ref0), .s_duv(s_duv0), .cout_ref(cout_ref0), .cout_duv(cout_duv0),
    .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0), .first_err_idx(first0)
  );

  adder_check_seq #(.N(4), .MODE(0), .NVEC(1024), .LAT(2), .SEED(SEED_V)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .a(a2), .b(b2), .cin(cin2),
    .s_ref(s_ref2), .s_duv(s_duv2), .cout_ref(cout_ref2), .cout_duv(cout_duv2),
    .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2), .first_err_idx(first2)
  );

  adder_check_seq #(.N(8), .MODE(1), .NVEC(100), .LAT(3), .SEED(SEED_V)) dut_r (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .a(a_r), .b(b_r), .cin(cin_r),
    .s_ref(s_ref_r), .s_duv(s_ref_r), .cout_ref(cout_ref_r), .cout_duv(cout_ref_r),
    .busy(busy_r), .done(done_r), .pass(pass_r), .err_cnt(err_r), .first_err_idx(first_r)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock of stimulus: drive at the falling edge, return just after the rising edge
  task automatic applyStimulus(input logic s, input logic ab);
    @(negedge clk);
    start = s;
    abort = ab;
    @(posedge clk);
    #1;
  endtask

  // Full run from a start pulse until all three instances report done
  task automatic runOne(input run_t r, input string tag);
    int          t0;
    int          t2;
    int          tr;
    int          c;
    logic [31:0] m;
    t0 = -1;
    t2 = -1;
    tr = -1;
    m  = SEED_V;
    fault = r.fault;
    applyStimulus(1'b1, 1'b0);
    checkOutput({tag, " vec0"},        {cin0, b0, a0}, 0);
    checkOutput({tag, " err_cleared"}, err0, 0);
    checkOutput({tag, " first_reset"}, first0, 32'hFFFF_FFFF);
    checkOutput({tag, " busy"},        busy0, 1);
    checkOutput({tag, " done_low"},    done0, 0);
    checkOutput({tag, " rnd_vec0"},    {cin_r, b_r, a_r}, m[16:0]);
    c = 0;
    while ((t0 < 0 || t2 < 0 || tr < 0) && c < 700) begin
      c++;
      applyStimulus(r.busy_start && (c == 10), 1'b0);
      if (t0 < 0 && done0) t0 = c;
      if (t2 < 0 && done2) t2 = c;
      if (tr < 0 && done_r) tr = c;
      if (c == 1 || c == 17 || c == 300 || c == 511)
        checkOutput($sformatf("%s vec%0d", tag, c), {cin0, b0, a0}, c);
      if (c == 300)
        checkOutput($sformatf("%s lat2_vec%0d", tag, c), {cin2, b2, a2}, c);
      if (c <= 2) begin
        m = model_step(m);
        checkOutput($sformatf("%s rnd_vec%0d", tag, c), {cin_r, b_r, a_r}, m[16:0]);
      end
    end
    checkOutput({tag, " done_cycle_lat0"}, t0, 512);
    checkOutput({tag, " done_cycle_lat2"}, t2, 514);
    checkOutput({tag, " done_cycle_rnd"},  tr, 103);
    checkOutput({tag, " done_held"},       done0, 1);
    checkOutput({tag, " err_lat0"},        err0, r.exp_err);
    checkOutput({tag, " first_lat0"},      first0, r.exp_first);
    checkOutput({tag, " pass_lat0"},       pass0, r.exp_pass);
    checkOutput({tag, " err_lat2"},        err2, r.exp_err);
    checkOutput({tag, " first_lat2"},      first2, r.exp_first);
    checkOutput({tag, " pass_lat2"},       pass2, r.exp_pass);
    checkOutput({tag, " err_rnd"},         err_r, 0);
    checkOutput({tag, " first_rnd"},       first_r, 32'hFFFF_FFFF);
    checkOutput({tag, " pass_rnd"},        pass_r, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    fault = 0;

    runs[0] = '{fault: 0, busy_start: 1'b0, exp_err: 0,   exp_first: 32'hFFFF_FFFF, exp_pass: 1'b1};
    runs[1] = '{fault: 1, busy_start: 1'b0, exp_err: 256, exp_first: 32'd1,         exp_pass: 1'b0};
    runs[2] = '{fault: 2, busy_start: 1'b0, exp_err: 256, exp_first: 32'd0,         exp_pass: 1'b0};
    runs[3] = '{fault: 3, busy_start: 1'b1, exp_err: 512, exp_first: 32'd0,         exp_pass: 1'b0};

    #12;
    checkOutput("reset a",     a0, 0);
    checkOutput("reset b",     b0, 0);
    checkOutput("reset cin",   cin0, 0);
    checkOutput("reset busy",  busy0, 0);
    checkOutput("reset done",  done0, 0);
    checkOutput("reset pass",  pass0, 0);
    checkOutput("reset err",   err0, 0);
    checkOutput("reset first", first0, 32'hFFFF_FFFF);
    checkOutput("reset rnd_a", a_r, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) runOne(runs[i], $sformatf("run%0d", i));

    // start and abort together in DONE: abort wins, results kept
    applyStimulus(1'b1, 1'b1);
    checkOutput("start_abort done",  done0, 0);
    checkOutput("start_abort busy",  busy0, 0);
    checkOutput("start_abort err",   err0, 512);
    checkOutput("start_abort rdone", done_r, 0);
    applyStimulus(1'b0, 1'b0);

    // abort in cycle 50 of a faulty run
    fault = 1;
    applyStimulus(1'b1, 1'b0);
    repeat (50) applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("abort busy0",  busy0, 0);
    checkOutput("abort done0",  done0, 0);
    checkOutput("abort busy2",  busy2, 0);
    checkOutput("abort busy_r", busy_r, 0);
    checkOutput("abort err0",   err0, 25);
    checkOutput("abort err2",   err2, 24);
    checkOutput("abort first0", first0, 1);
    checkOutput("abort first2", first2, 1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("abort done_stays0", done0, 0);
    checkOutput("abort done_stays2", done2, 0);
    runOne(runs[0], "after_abort");

    // asynchronous reset pulse between edges in cycle 30
    fault = 1;
    applyStimulus(1'b1, 1'b0);
    repeat (30) applyStimulus(1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst a",     a0, 0);
    checkOutput("async_rst b",     b0, 0);
    checkOutput("async_rst cin",   cin0, 0);
    checkOutput("async_rst busy",  busy0, 0);
    checkOutput("async_rst done",  done0, 0);
    checkOutput("async_rst pass",  pass0, 0);
    checkOutput("async_rst err",   err0, 0);
    checkOutput("async_rst first", first0, 32'hFFFF_FFFF);
    checkOutput("async_rst busy_r", busy_r, 0);
    #2;
    rst_n = 1'b1;
    runOne(runs[0], "after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
